// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, oversampling
// factor and helpers that size the baud tick divider.
package uart_pkg;

    localparam int OVS = 16;

    // Tick index inside one bit at which the start bit is checked (mid bit)
    // and at which data/stop bits are sampled (one full bit later).
    localparam logic [3:0] TCNT_MID  = 4'd7;
    localparam logic [3:0] TCNT_LAST = 4'd15;
    localparam logic [2:0] BCNT_LAST = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_e;

    // Rounded clk cycles per oversampling tick.
    function automatic int calc_div(input int clk_hz, input int baud, input int ovs);
        return (clk_hz + (baud * ovs) / 2) / (baud * ovs);
    endfunction

    // Width of a counter that must hold 0..div-1.
    function automatic int div_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: counts 0..DIV-1 and pulses tick on the wrap.
// Held at zero while clear is high so a frame always starts on a fresh phase.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV = 54
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int            W    = div_width(DIV);
    localparam logic [W-1:0]  LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: cleared on request, otherwise wraps at DIV-1.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with 16x oversampling. Presents each good byte on
// rx_data with a one-cycle rx_ready strobe; a low stop bit raises a
// one-cycle frame_error and the receiver waits for the line to go high.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200,
    parameter int OVS    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       frame_error,
    output logic       busy
);

    localparam int DIV = calc_div(CLK_HZ, BAUD, OVS);

    // Synchronizer
    logic rx_meta_q, rx_meta_d;
    logic rx_s_q,    rx_s_d;

    // FSM and datapath
    rx_state_e  state_q, state_d;
    logic [3:0] tcnt_q,  tcnt_d;
    logic [2:0] bcnt_q,  bcnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_ready_q, rx_ready_d;
    logic       frame_error_q, frame_error_d;

    logic tick;
    logic tick_clear;

    // The divider only runs while a frame is in progress.
    assign tick_clear = (state_q == IDLE) || (state_q == WAIT_HIGH);

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .clear (tick_clear),
        .tick  (tick)
    );

    // Two-stage synchronizer path for the asynchronous line.
    always_comb begin
        // NOTE: rx is asynchronous to clk; only rx_s_q may be used by logic,
        // the first stage exists to absorb metastability.
        rx_meta_d = rx;
        rx_s_d    = rx_meta_q;
    end

    // Next-state, counter, shift register and strobe logic.
    always_comb begin
        state_d       = state_q;
        tcnt_d        = tcnt_q;
        bcnt_d        = bcnt_q;
        shreg_d       = shreg_q;
        rx_data_d     = rx_data_q;
        rx_ready_d    = 1'b0;
        frame_error_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    tcnt_d  = '0;
                end
            end

            START: begin
                if (tick) begin
                    if (tcnt_q == TCNT_MID) begin
                        if (rx_s_q) begin
                            // Start bit vanished by mid bit: a glitch.
                            state_d = IDLE;
                        end else begin
                            tcnt_d  = '0;
                            bcnt_d  = '0;
                            state_d = DATA;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 4'd1;
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    // tcnt wraps 15 -> 0 naturally at each bit boundary.
                    tcnt_d = tcnt_q + 4'd1;
                    if (tcnt_q == TCNT_LAST) begin
                        shreg_d = {rx_s_q, shreg_q[7:1]};
                        bcnt_d  = bcnt_q + 3'd1;
                        if (bcnt_q == BCNT_LAST) begin
                            state_d = STOP;
                        end
                    end
                end
            end

            STOP: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 4'd1;
                    if (tcnt_q == TCNT_LAST) begin
                        if (rx_s_q) begin
                            rx_data_d  = shreg_q;
                            rx_ready_d = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            frame_error_d = 1'b1;
                            state_d       = WAIT_HIGH;
                        end
                    end
                end
            end

            WAIT_HIGH: begin
                // Hold off through a break so it cannot look like a start bit.
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state registers; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            state_q       <= IDLE;
            tcnt_q        <= '0;
            bcnt_q        <= '0;
            shreg_q       <= '0;
            rx_data_q     <= '0;
            rx_ready_q    <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            rx_meta_q     <= rx_meta_d;
            rx_s_q        <= rx_s_d;
            state_q       <= state_d;
            tcnt_q        <= tcnt_d;
            bcnt_q        <= bcnt_d;
            shreg_q       <= shreg_d;
            rx_data_q     <= rx_data_d;
            rx_ready_q    <= rx_ready_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_ready    = rx_ready_q;
    assign frame_error = frame_error_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at the default 100 MHz / 115200 baud
// (864 clk per bit, DIV = 54). Stimulus changes on the falling clock edge.
module tb_uart_rx_byte;

    localparam int BIT_CLK  = 864;
    localparam int SKEW_CLK = 881;   // ~+2% longer bits
    // Start edge -> rx_ready: 3 clk (sync + IDLE exit) + 152 ticks * 54 clk.
    localparam int RDY_LAT  = 8211;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       frame_error;
    logic       busy;

    int vectors;
    int miscompares;
    int cyc;
    int ready_cnt;
    int fe_cnt;
    int overlap_cnt;
    int last_ready_cyc;
    logic [7:0] ready_data[$];

    uart_rx_byte dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .frame_error (frame_error),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rx_ready === 1'b1) begin
            ready_cnt++;
            ready_data.push_back(rx_data);
            last_ready_cyc = cyc;
        end
        if (frame_error === 1'b1) fe_cnt++;
        if (rx_ready === 1'b1 && frame_error === 1'b1) overlap_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_next_byte(input string tag, input logic [7:0] exp);
        if (ready_data.size() == 0) check(tag, 32'hDEAD, {24'h0, exp});
        else check(tag, {24'h0, ready_data.pop_front()}, {24'h0, exp});
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One 8N1 character, LSB first; the line is left at the stop-bit level.
    task automatic send_byte(input logic [7:0] b, input int bclk, input logic stop_bit,
                             output int t_start);
        rx = 1'b0;
        t_start = cyc;
        wait_clks(bclk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clks(bclk);
        end
        rx = stop_bit;
        wait_clks(bclk);
    endtask

    initial begin
        int t0;
        int r1;
        int rdy_base;
        int fe_base;

        vectors = 0; miscompares = 0; cyc = 0;
        ready_cnt = 0; fe_cnt = 0; overlap_cnt = 0; last_ready_cyc = 0;
        rx = 1'b1;
        reset = 1'b1;
        wait_clks(4);
        check("reset_rx_data", {24'h0, rx_data}, 32'h00);
        check("reset_busy", {31'h0, busy}, 32'h0);
        reset = 1'b0;
        wait_clks(20);
        check("idle_ready", {31'h0, rx_ready}, 32'h0);
        check("idle_ferr", {31'h0, frame_error}, 32'h0);

        // Single character 0x55.
        send_byte(8'h55, BIT_CLK, 1'b1, t0);
        wait_clks(100);
        check("t1_ready_cnt", ready_cnt, 1);
        check_next_byte("t1_data", 8'h55);
        check("t1_latency", last_ready_cyc - t0, RDY_LAT);
        check("t1_ferr_cnt", fe_cnt, 0);

        // Back-to-back 0xA3, 0x0F with a single stop bit between them.
        rdy_base = ready_cnt;
        send_byte(8'hA3, BIT_CLK, 1'b1, t0);
        r1 = last_ready_cyc;
        send_byte(8'h0F, BIT_CLK, 1'b1, t0);
        wait_clks(100);
        check("t2_ready_cnt", ready_cnt - rdy_base, 2);
        check_next_byte("t2_data0", 8'hA3);
        check_next_byte("t2_data1", 8'h0F);
        check("t2_spacing", last_ready_cyc - r1, 8640);

        // Short low glitch (3*DIV clk) is rejected at mid start bit.
        rdy_base = ready_cnt;
        fe_base  = fe_cnt;
        rx = 1'b0;
        wait_clks(100);
        check("t3_busy_in_glitch", {31'h0, busy}, 32'h1);
        wait_clks(62);
        rx = 1'b1;
        wait_clks(600);
        check("t3_busy_after", {31'h0, busy}, 32'h0);
        check("t3_ready_cnt", ready_cnt - rdy_base, 0);
        check("t3_ferr_cnt", fe_cnt - fe_base, 0);

        // 0x3C with a low stop bit, then a 2-bit break.
        rdy_base = ready_cnt;
        fe_base  = fe_cnt;
        send_byte(8'h3C, BIT_CLK, 1'b0, t0);
        wait_clks(BIT_CLK);
        check("t4_busy_mid_break", {31'h0, busy}, 32'h1);
        wait_clks(BIT_CLK);
        check("t4_busy_end_break", {31'h0, busy}, 32'h1);
        check("t4_ferr_cnt", fe_cnt - fe_base, 1);
        check("t4_ready_cnt", ready_cnt - rdy_base, 0);
        check("t4_data_held", {24'h0, rx_data}, 32'h0F);
        rx = 1'b1;
        wait_clks(5);
        check("t4_busy_released", {31'h0, busy}, 32'h0);
        wait_clks(200);

        // Reset pulse in the middle of the data bits of 0xFF.
        rdy_base = ready_cnt;
        fe_base  = fe_cnt;
        rx = 1'b0;
        wait_clks(BIT_CLK);
        rx = 1'b1;
        wait_clks(4 * BIT_CLK);
        reset = 1'b1;
        wait_clks(1);
        reset = 1'b0;
        check("t5_rst_data", {24'h0, rx_data}, 32'h00);
        check("t5_rst_busy", {31'h0, busy}, 32'h0);
        check("t5_rst_ready", {31'h0, rx_ready}, 32'h0);
        check("t5_rst_ferr", {31'h0, frame_error}, 32'h0);
        wait_clks(2 * BIT_CLK);
        check("t5_no_strobe", ready_cnt - rdy_base, 0);
        check("t5_no_ferr", fe_cnt - fe_base, 0);
        send_byte(8'h81, BIT_CLK, 1'b1, t0);
        wait_clks(100);
        check("t5_ready_cnt", ready_cnt - rdy_base, 1);
        check_next_byte("t5_data", 8'h81);

        // +2% baud skew, three characters back to back.
        rdy_base = ready_cnt;
        fe_base  = fe_cnt;
        send_byte(8'h11, SKEW_CLK, 1'b1, t0);
        send_byte(8'h22, SKEW_CLK, 1'b1, t0);
        send_byte(8'h33, SKEW_CLK, 1'b1, t0);
        wait_clks(200);
        check("t6_ready_cnt", ready_cnt - rdy_base, 3);
        check_next_byte("t6_data0", 8'h11);
        check_next_byte("t6_data1", 8'h22);
        check_next_byte("t6_data2", 8'h33);
        check("t6_ferr_cnt", fe_cnt - fe_base, 0);

        check("strobe_overlap", overlap_cnt, 0);
        check("data_queue_empty", ready_data.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
